// File: rtl/uart_byte_rx_pkg.sv
// Shared types, clock/baud defaults and helpers for the UART byte receiver.
package uart_byte_rx_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF   = 115_200;

  typedef logic [7:0] byte_t;

  // Rounded clocks-per-sample-tick divider.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + baud * os / 2) / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Received-byte stream (valid/ready) plus line status toward the command decoder.
interface uart_byte_rx_if;
  import uart_byte_rx_pkg::*;

  byte_t rx_data;
  logic  rx_valid;
  logic  rx_ready;
  logic  frame_err;
  logic  overrun;
  logic  busy;

  modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divide-by-DIV counter; tick_o is high in the cycle the count is DIV-1.
// A synchronous clear restarts the phase so callers can align to a line edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority, false-start rejection,
// framing-error/break handling and a one-deep holding register with overrun flag.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           rxd_i,
  uart_byte_rx_if.master rx
);
  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

  state_e       state_q;
  logic         rxd_meta_q, rxs_q;
  logic [SW-1:0] samp_q;
  logic [2:0]   bit_idx_q;
  logic         s_lo_q, s_mid_q;
  byte_t        shift_q, data_q;
  logic         valid_q, frame_err_q, overrun_q;

  logic tick, clr, decide, maj, stop_ok, bit_end;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxs_q      <= rxd_meta_q;
    end
  end

  // Restarting the divider on the detected edge puts sample ticks in phase with the frame.
  assign clr = (state_q == IDLE) && !rxs_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (clr),
    .tick_o(tick)
  );

  assign decide  = tick && (samp_q == S_HI);
  assign bit_end = tick && (samp_q == S_LAST);
  assign maj     = maj3(s_lo_q, s_mid_q, rxs_q);
  assign stop_ok = (state_q == STOP) && decide && maj;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      samp_q      <= '0;
      bit_idx_q   <= '0;
      s_lo_q      <= 1'b1;
      s_mid_q     <= 1'b1;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (tick && (state_q == START || state_q == DATA || state_q == STOP)) begin
        samp_q <= (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
        if (samp_q == S_LO)  s_lo_q  <= rxs_q;
        if (samp_q == S_MID) s_mid_q <= rxs_q;
      end

      case (state_q)
        IDLE: if (!rxs_q) begin
          samp_q  <= '0;
          state_q <= START;
        end
        START: begin
          if (decide && maj) state_q <= IDLE;
          else if (bit_end) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (decide) shift_q <= {maj, shift_q[7:1]};
          if (bit_end) begin
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        // Leave mid-stop-bit so the next start edge is never missed.
        STOP: if (decide) begin
          if (maj) state_q <= IDLE;
          else begin
            frame_err_q <= 1'b1;
            state_q     <= BRK;
          end
        end
        BRK: if (rxs_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (stop_ok) begin
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;
  assign rx.busy      = (state_q != IDLE);
endmodule
